// File: rtl/sysarr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sysarr_pkg
//  Description : Shared constants, FSM state encoding and FP16 helper for the
//                3x3 systolic-array feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package sysarr_pkg;

    localparam int DW     = 16;        // FP16 word width
    localparam int N      = 3;         // matrix dimension
    localparam int NN     = N * N;     // words per matrix
    localparam int NLANE  = 2 * N - 1; // west / north lanes driven
    localparam int NFETCH = 2 * NN;    // words fetched per run (A then B)
    localparam int IDX_W  = 5;         // width of a fetch index 0..NFETCH-1

    // IEEE-754 binary16 exponent field
    localparam int          FP16_EXP_MSB  = 14;
    localparam int          FP16_EXP_LSB  = 10;
    localparam logic [4:0]  FP16_EXP_ONES = 5'h1F;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_DRAIN = 4'd2,
        ST_FLUSH = 4'd3,
        ST_WAVE0 = 4'd4,
        ST_WAVE1 = 4'd5,
        ST_WAVE2 = 4'd6,
        ST_TAIL  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // An all-ones exponent encodes Inf or NaN.
    function automatic logic fp16_is_special(input logic [DW-1:0] w);
        return w[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_ONES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysarray_feeder_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : DEPTH-deep shift register of {valid, index} tags that tracks
//                outstanding block-RAM reads. The tag of a read issued in
//                cycle c appears on the outputs in cycle c+DEPTH, the same
//                cycle the RAM returns the data.
//  Ports       : clock, reset     - clock, synchronous active-high reset
//                in_valid/in_idx  - tag of the read issued this cycle
//                out_valid/out_idx- tag of the read whose data is on the bus
//  Revision    : 1.0  initial release
// ============================================================================
module rd_tag_pipe
#(
    parameter int DEPTH = 2,
    parameter int IW    = sysarr_pkg::IDX_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);
    import sysarr_pkg::*;

    logic [IW:0] stage_q [DEPTH];
    logic [IW:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = {in_valid, in_idx};
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid = stage_q[DEPTH-1][IW];
    assign out_idx   = stage_q[DEPTH-1][IW-1:0];

endmodule
`default_nettype wire

// File: rtl/sysarray_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sysarray_feeder
//  Description : Loads two row-major 3x3 FP16 matrices (A then B) from a
//                single-port BRAM and drives the systolic array's west (a)
//                and north (b) inputs with a diagonally skewed three-wave
//                schedule followed by zero tail cycles.
//  Ports       : clock, reset        - clock, synchronous active-high reset
//                start               - begin a run (sampled only in IDLE)
//                busy, done, launch  - run status / pulses
//                mem_en, mem_addr,
//                mem_rdata           - BRAM read port
//                a_out0..4, b_out0..4- array west / north inputs
//                c_out0..4           - array c inputs, constant zero
//                nan_flag            - sticky: Inf/NaN word loaded this run
//  Options     : SYSARR_FEEDER_NANCHK_EN builds the Inf/NaN detector;
//                without it nan_flag is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module sysarray_feeder
#(
    parameter int DW       = 16,
    parameter int AW       = 5,
    parameter int BASE_A   = 0,
    parameter int BASE_B   = 9,
    parameter int RD_LAT   = 2,
    parameter int TAIL_CYC = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          launch,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] a_out0,
    output logic [DW-1:0] a_out1,
    output logic [DW-1:0] a_out2,
    output logic [DW-1:0] a_out3,
    output logic [DW-1:0] a_out4,
    output logic [DW-1:0] b_out0,
    output logic [DW-1:0] b_out1,
    output logic [DW-1:0] b_out2,
    output logic [DW-1:0] b_out3,
    output logic [DW-1:0] b_out4,
    output logic [DW-1:0] c_out0,
    output logic [DW-1:0] c_out1,
    output logic [DW-1:0] c_out2,
    output logic [DW-1:0] c_out3,
    output logic [DW-1:0] c_out4,
    output logic          nan_flag
);
    import sysarr_pkg::*;

    localparam int CW = 8;  // shared fetch / drain / tail counter width

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            launch_q, launch_d;
    logic            mem_en_q, mem_en_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;

    logic [DW-1:0]   a_mat_q [NN];
    logic [DW-1:0]   a_mat_d [NN];
    logic [DW-1:0]   b_mat_q [NN];
    logic [DW-1:0]   b_mat_d [NN];
    logic [DW-1:0]   a_q [NLANE];
    logic [DW-1:0]   a_d [NLANE];
    logic [DW-1:0]   b_q [NLANE];
    logic [DW-1:0]   b_d [NLANE];

    logic            tag_valid;
    logic [IDX_W-1:0] tag_idx;
    logic            load_en;
    logic [1:0]      load_w;

    // Fetch index 0..8 maps into A, 9..17 into B.
    function automatic logic [AW-1:0] fetch_addr(input logic [CW-1:0] idx);
        if (idx < CW'(NN)) begin
            return AW'(BASE_A + int'(idx));
        end
        return AW'(BASE_B + int'(idx) - NN);
    endfunction

    rd_tag_pipe #(
        .DEPTH (RD_LAT),
        .IW    (IDX_W)
    ) u_rd_tag_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (mem_en_q),
        .in_idx    (cnt_q[IDX_W-1:0]),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        launch_d   = 1'b0;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        load_en    = 1'b0;
        load_w     = 2'd0;
        for (int i = 0; i < NN; i++) begin
            a_mat_d[i] = a_mat_q[i];
            b_mat_d[i] = b_mat_q[i];
        end
        for (int i = 0; i < NLANE; i++) begin
            a_d[i] = '0;
            b_d[i] = '0;
        end

        // Retire the read whose data is on the bus this cycle.
        if (tag_valid) begin
            if (tag_idx < IDX_W'(NN)) begin
                a_mat_d[tag_idx[3:0]] = mem_rdata;
            end else begin
                b_mat_d[4'(tag_idx - IDX_W'(NN))] = mem_rdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = fetch_addr('0);
                    for (int i = 0; i < NN; i++) begin
                        a_mat_d[i] = '0;
                        b_mat_d[i] = '0;
                    end
                end
            end
            ST_FETCH: begin
                // cnt_q is the index of the address presented this cycle.
                if (cnt_q == CW'(NFETCH - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    mem_en_d   = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                    mem_addr_d = fetch_addr(cnt_q + CW'(1));
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    state_d = ST_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FLUSH: begin
                state_d  = ST_WAVE0;
                launch_d = 1'b1;
                load_en  = 1'b1;
                load_w   = 2'd0;
            end
            ST_WAVE0: begin
                state_d = ST_WAVE1;
                load_en = 1'b1;
                load_w  = 2'd1;
            end
            ST_WAVE1: begin
                state_d = ST_WAVE2;
                load_en = 1'b1;
                load_w  = 2'd2;
            end
            ST_WAVE2: begin
                cnt_d = '0;
                if (TAIL_CYC == 0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (cnt_q == CW'(TAIL_CYC - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Wave w: row w of A enters lanes w..w+2, column w of B likewise,
        // so each successive wave shifts one lane further along the skew.
        if (load_en) begin
            for (int r = 0; r < N; r++) begin
                a_d[int'(load_w) + r] = a_mat_q[N * int'(load_w) + r];
                b_d[int'(load_w) + r] = b_mat_q[N * r + int'(load_w)];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            launch_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            for (int i = 0; i < NN; i++) begin
                a_mat_q[i] <= '0;
                b_mat_q[i] <= '0;
            end
            for (int i = 0; i < NLANE; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            launch_q   <= launch_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            for (int i = 0; i < NN; i++) begin
                a_mat_q[i] <= a_mat_d[i];
                b_mat_q[i] <= b_mat_d[i];
            end
            for (int i = 0; i < NLANE; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

`ifdef SYSARR_FEEDER_NANCHK_EN
    logic nan_q, nan_d;

    always_comb begin
        nan_d = nan_q;
        if (state_q == ST_IDLE && start) begin
            nan_d = 1'b0;
        end else if (tag_valid && fp16_is_special(mem_rdata)) begin
            nan_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nan_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
        end
    end

    assign nan_flag = nan_q;
`else
    assign nan_flag = 1'b0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign launch   = launch_q;
    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;

    assign a_out0 = a_q[0];
    assign a_out1 = a_q[1];
    assign a_out2 = a_q[2];
    assign a_out3 = a_q[3];
    assign a_out4 = a_q[4];
    assign b_out0 = b_q[0];
    assign b_out1 = b_q[1];
    assign b_out2 = b_q[2];
    assign b_out3 = b_q[3];
    assign b_out4 = b_q[4];

    assign c_out0 = '0;
    assign c_out1 = '0;
    assign c_out2 = '0;
    assign c_out3 = '0;
    assign c_out4 = '0;

endmodule
`default_nettype wire

// File: tb/tb_sysarray_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysarray_feeder
//  Description : Self-checking bench for sysarray_feeder. One instance with
//                RD_LAT=2 carries the main checks; two more with RD_LAT=1
//                and RD_LAT=3 share start/reset and the memory image.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sysarray_feeder;

`ifdef SYSARR_FEEDER_NANCHK_EN
    localparam logic NAN_EXP = 1'b1;
`else
    localparam logic NAN_EXP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] mem [32];

    // ---------------- main instance (RD_LAT = 2) ----------------
    logic        m_busy, m_done, m_launch, m_en, m_nan;
    logic [4:0]  m_addr;
    logic [15:0] m_rd;
    logic [15:0] m_a [5];
    logic [15:0] m_b [5];
    logic [15:0] m_c [5];
    logic [15:0] m_p [2];

    always @(posedge clock) begin
        m_p[0] <= m_en ? mem[m_addr] : 16'hDEAD;
        m_p[1] <= m_p[0];
    end
    assign m_rd = m_p[1];

    sysarray_feeder #(.DW(16), .AW(5), .BASE_A(0), .BASE_B(9), .RD_LAT(2), .TAIL_CYC(5)) dut (
        .clock(clock), .reset(reset), .start(start),
        .busy(m_busy), .done(m_done), .launch(m_launch),
        .mem_en(m_en), .mem_addr(m_addr), .mem_rdata(m_rd),
        .a_out0(m_a[0]), .a_out1(m_a[1]), .a_out2(m_a[2]), .a_out3(m_a[3]), .a_out4(m_a[4]),
        .b_out0(m_b[0]), .b_out1(m_b[1]), .b_out2(m_b[2]), .b_out3(m_b[3]), .b_out4(m_b[4]),
        .c_out0(m_c[0]), .c_out1(m_c[1]), .c_out2(m_c[2]), .c_out3(m_c[3]), .c_out4(m_c[4]),
        .nan_flag(m_nan)
    );

    // ---------------- RD_LAT = 1 instance ----------------
    logic        s1_busy, s1_done, s1_launch, s1_en, s1_nan;
    logic [4:0]  s1_addr;
    logic [15:0] s1_rd;
    logic [15:0] s1_a [5];
    logic [15:0] s1_b [5];
    logic [15:0] s1_c [5];

    always @(posedge clock) s1_rd <= s1_en ? mem[s1_addr] : 16'hDEAD;

    sysarray_feeder #(.DW(16), .AW(5), .BASE_A(0), .BASE_B(9), .RD_LAT(1), .TAIL_CYC(5)) dut_lat1 (
        .clock(clock), .reset(reset), .start(start),
        .busy(s1_busy), .done(s1_done), .launch(s1_launch),
        .mem_en(s1_en), .mem_addr(s1_addr), .mem_rdata(s1_rd),
        .a_out0(s1_a[0]), .a_out1(s1_a[1]), .a_out2(s1_a[2]), .a_out3(s1_a[3]), .a_out4(s1_a[4]),
        .b_out0(s1_b[0]), .b_out1(s1_b[1]), .b_out2(s1_b[2]), .b_out3(s1_b[3]), .b_out4(s1_b[4]),
        .c_out0(s1_c[0]), .c_out1(s1_c[1]), .c_out2(s1_c[2]), .c_out3(s1_c[3]), .c_out4(s1_c[4]),
        .nan_flag(s1_nan)
    );

    // ---------------- RD_LAT = 3 instance ----------------
    logic        s3_busy, s3_done, s3_launch, s3_en, s3_nan;
    logic [4:0]  s3_addr;
    logic [15:0] s3_rd;
    logic [15:0] s3_a [5];
    logic [15:0] s3_b [5];
    logic [15:0] s3_c [5];
    logic [15:0] s3_p [3];

    always @(posedge clock) begin
        s3_p[0] <= s3_en ? mem[s3_addr] : 16'hDEAD;
        s3_p[1] <= s3_p[0];
        s3_p[2] <= s3_p[1];
    end
    assign s3_rd = s3_p[2];

    sysarray_feeder #(.DW(16), .AW(5), .BASE_A(0), .BASE_B(9), .RD_LAT(3), .TAIL_CYC(5)) dut_lat3 (
        .clock(clock), .reset(reset), .start(start),
        .busy(s3_busy), .done(s3_done), .launch(s3_launch),
        .mem_en(s3_en), .mem_addr(s3_addr), .mem_rdata(s3_rd),
        .a_out0(s3_a[0]), .a_out1(s3_a[1]), .a_out2(s3_a[2]), .a_out3(s3_a[3]), .a_out4(s3_a[4]),
        .b_out0(s3_b[0]), .b_out1(s3_b[1]), .b_out2(s3_b[2]), .b_out3(s3_b[3]), .b_out4(s3_b[4]),
        .c_out0(s3_c[0]), .c_out1(s3_c[1]), .c_out2(s3_c[2]), .c_out3(s3_c[3]), .c_out4(s3_c[4]),
        .nan_flag(s3_nan)
    );

    // Lane vectors, lane 0 in the low 16 bits.
    wire [79:0] m_av  = {m_a[4], m_a[3], m_a[2], m_a[1], m_a[0]};
    wire [79:0] m_bv  = {m_b[4], m_b[3], m_b[2], m_b[1], m_b[0]};
    wire [79:0] m_cv  = {m_c[4], m_c[3], m_c[2], m_c[1], m_c[0]};
    wire [79:0] s1_av = {s1_a[4], s1_a[3], s1_a[2], s1_a[1], s1_a[0]};
    wire [79:0] s1_bv = {s1_b[4], s1_b[3], s1_b[2], s1_b[1], s1_b[0]};
    wire [79:0] s3_av = {s3_a[4], s3_a[3], s3_a[2], s3_a[1], s3_a[0]};
    wire [79:0] s3_bv = {s3_b[4], s3_b[3], s3_b[2], s3_b[1], s3_b[0]};

    // Hand-computed waves for A[i]=i+1, B[i]=0x10+i.
    localparam logic [79:0] Z80 = 80'h0;
    localparam logic [79:0] WA0 = {16'h0000, 16'h0000, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [79:0] WB0 = {16'h0000, 16'h0000, 16'h0016, 16'h0013, 16'h0010};
    localparam logic [79:0] WA1 = {16'h0000, 16'h0006, 16'h0005, 16'h0004, 16'h0000};
    localparam logic [79:0] WB1 = {16'h0000, 16'h0017, 16'h0014, 16'h0011, 16'h0000};
    localparam logic [79:0] WA2 = {16'h0009, 16'h0008, 16'h0007, 16'h0000, 16'h0000};
    localparam logic [79:0] WB2 = {16'h0018, 16'h0015, 16'h0012, 16'h0000, 16'h0000};
    // Wave 0 for A=0x3C00 x9, B=0x4000 x9.
    localparam logic [79:0] PA0 = {16'h0000, 16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
    localparam logic [79:0] PB0 = {16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000};

    typedef struct {
        int          cyc;
        logic        busy;
        logic        en;
        logic        chk_addr;
        logic [4:0]  addr;
        logic        lau;
        logic        dn;
        logic [79:0] a;
        logic [79:0] b;
    } vec_t;

    vec_t tbl [14];

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;
    int f1     = -1;
    int f3     = -1;
    logic [79:0] h1a [64];
    logic [79:0] h1b [64];
    logic [79:0] h3a [64];
    logic [79:0] h3b [64];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, k, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        k++;
        if (k >= 0 && k < 64) begin
            h1a[k] = s1_av; h1b[k] = s1_bv;
            h3a[k] = s3_av; h3b[k] = s3_bv;
        end
        if (s1_launch && f1 < 0) f1 = k;
        if (s3_launch && f3 < 0) f3 = k;
    endtask

    task automatic step_to(input int c);
        while (k < c) step();
    endtask

    // Pulses start; afterwards the bench sits in cycle 1 of the run.
    task automatic launch_run(input bit hold);
        f1 = -1; f3 = -1;
        k = 0;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_busy || s1_busy || s3_busy) && t < 80) begin
            step();
            t++;
        end
        if (t >= 80) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: busy still %b%b%b, required 000", m_busy, s1_busy, s3_busy);
        end
    endtask

    task automatic fill(input logic [15:0] abase, input logic [15:0] ainc,
                        input logic [15:0] bbase, input logic [15:0] binc);
        for (int i = 0; i < 32; i++) mem[i] = 16'hBAD0;
        for (int i = 0; i < 9; i++) begin
            mem[i]     = abase + ainc * 16'(i);
            mem[9 + i] = bbase + binc * 16'(i);
        end
    endtask

    function automatic logic [79:0] exp_wave(input int w, input bit is_b);
        logic [79:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            v[16*(w+r) +: 16] = is_b ? mem[9 + 3*r + w] : mem[3*w + r];
        end
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{cyc:1,  busy:1'b1, en:1'b1, chk_addr:1'b1, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[1]  = '{cyc:9,  busy:1'b1, en:1'b1, chk_addr:1'b1, addr:5'd8,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[2]  = '{cyc:10, busy:1'b1, en:1'b1, chk_addr:1'b1, addr:5'd9,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[3]  = '{cyc:18, busy:1'b1, en:1'b1, chk_addr:1'b1, addr:5'd17, lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[4]  = '{cyc:19, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[5]  = '{cyc:20, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[6]  = '{cyc:21, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[7]  = '{cyc:22, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b1, dn:1'b0, a:WA0, b:WB0};
        tbl[8]  = '{cyc:23, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:WA1, b:WB1};
        tbl[9]  = '{cyc:24, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:WA2, b:WB2};
        tbl[10] = '{cyc:25, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[11] = '{cyc:29, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};
        tbl[12] = '{cyc:30, busy:1'b1, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b1, a:Z80, b:Z80};
        tbl[13] = '{cyc:31, busy:1'b0, en:1'b0, chk_addr:1'b0, addr:5'd0,  lau:1'b0, dn:1'b0, a:Z80, b:Z80};

        // ---------------- reset state ----------------
        fill(16'h3C00, 16'h0, 16'h4000, 16'h0);
        reset = 1'b1;
        step(); step(); step();
        chk("rst_busy",   80'(m_busy),   Z80);
        chk("rst_done",   80'(m_done),   Z80);
        chk("rst_launch", 80'(m_launch), Z80);
        chk("rst_mem_en", 80'(m_en),     Z80);
        chk("rst_addr",   80'(m_addr),   Z80);
        chk("rst_nan",    80'(m_nan),    Z80);
        chk("rst_a",      m_av,          Z80);
        chk("rst_b",      m_bv,          Z80);
        chk("rst_c",      m_cv,          Z80);
        reset = 1'b0;
        step();

        // ---------------- uniform pattern: address walk, wave0, done ----
        launch_run(1'b0);
        for (int i = 1; i <= 18; i++) begin
            chk("p1_fetch_en",   80'(m_en),   80'(1));
            chk("p1_fetch_addr", 80'(m_addr), 80'(i - 1));
            step();
        end
        step_to(22);
        chk("p1_wave0_a", m_av, PA0);
        chk("p1_wave0_b", m_bv, PB0);
        while (!m_done && k < 45) step();
        chk("p1_done_cycle", 80'(k), 80'(30));
        wait_idle();

        // ---------------- indexed pattern: cycle table ----------------
        fill(16'h0001, 16'h1, 16'h0010, 16'h1);
        launch_run(1'b0);
        for (int i = 0; i < 14; i++) begin
            step_to(tbl[i].cyc);
            chk("tbl_busy",   80'(m_busy),   80'(tbl[i].busy));
            chk("tbl_mem_en", 80'(m_en),     80'(tbl[i].en));
            if (tbl[i].chk_addr) chk("tbl_addr", 80'(m_addr), 80'(tbl[i].addr));
            chk("tbl_launch", 80'(m_launch), 80'(tbl[i].lau));
            chk("tbl_done",   80'(m_done),   80'(tbl[i].dn));
            chk("tbl_a",      m_av,          tbl[i].a);
            chk("tbl_b",      m_bv,          tbl[i].b);
            chk("tbl_c",      m_cv,          Z80);
        end
        wait_idle();

        // ---------------- RD_LAT sweep ----------------
        chk("lat1_launch_cycle", 80'(f1), 80'(21));
        chk("lat3_launch_cycle", 80'(f3), 80'(23));
        chk("lat1_wave0_a", h1a[21], WA0);  chk("lat1_wave0_b", h1b[21], WB0);
        chk("lat1_wave1_a", h1a[22], WA1);  chk("lat1_wave1_b", h1b[22], WB1);
        chk("lat1_wave2_a", h1a[23], WA2);  chk("lat1_wave2_b", h1b[23], WB2);
        chk("lat3_wave0_a", h3a[23], WA0);  chk("lat3_wave0_b", h3b[23], WB0);
        chk("lat3_wave1_a", h3a[24], WA1);  chk("lat3_wave1_b", h3b[24], WB1);
        chk("lat3_wave2_a", h3a[25], WA2);  chk("lat3_wave2_b", h3b[25], WB2);

        // ---------------- start held high ----------------
        launch_run(1'b1);
        step_to(30);
        chk("hold_done",       80'(m_done), 80'(1));
        step();
        chk("hold_idle_busy",  80'(m_busy), 80'(0));
        chk("hold_idle_en",    80'(m_en),   80'(0));
        step();
        chk("hold_rerun_busy", 80'(m_busy), 80'(1));
        chk("hold_rerun_en",   80'(m_en),   80'(1));
        chk("hold_rerun_addr", 80'(m_addr), 80'(0));
        start = 1'b0;
        wait_idle();

        // ---------------- reset during FETCH ----------------
        launch_run(1'b0);
        step_to(10);
        reset = 1'b1;
        step();
        chk("rst_fetch_busy",   80'(m_busy),   80'(0));
        chk("rst_fetch_en",     80'(m_en),     80'(0));
        chk("rst_fetch_addr",   80'(m_addr),   80'(0));
        chk("rst_fetch_launch", 80'(m_launch), 80'(0));
        chk("rst_fetch_a",      m_av,          Z80);
        reset = 1'b0;
        fill(16'h0100, 16'h1, 16'h0200, 16'h1);
        step();
        wait_idle();
        launch_run(1'b0);
        step_to(22);
        chk("fresh_wave0_a", m_av, exp_wave(0, 1'b0));
        chk("fresh_wave0_b", m_bv, exp_wave(0, 1'b1));
        step();
        chk("fresh_wave1_a", m_av, exp_wave(1, 1'b0));
        chk("fresh_wave1_b", m_bv, exp_wave(1, 1'b1));
        step();
        chk("fresh_wave2_a", m_av, exp_wave(2, 1'b0));
        chk("fresh_wave2_b", m_bv, exp_wave(2, 1'b1));
        wait_idle();

        // ---------------- Inf/NaN flag ----------------
        fill(16'h0001, 16'h1, 16'h0010, 16'h1);
        mem[9 + 4] = 16'h7E00;
        launch_run(1'b0);
        step_to(5);
        chk("nan_before_capture", 80'(m_nan), 80'(0));
        step_to(23);
        chk("nan_passthru_b", m_bv, exp_wave(1, 1'b1));
        chk("nan_after_capture", 80'(m_nan), 80'(NAN_EXP));
        wait_idle();
        chk("nan_sticky_idle", 80'(m_nan), 80'(NAN_EXP));
        fill(16'h0001, 16'h1, 16'h0010, 16'h1);
        launch_run(1'b0);
        chk("nan_cleared_on_start", 80'(m_nan), 80'(0));
        step_to(22);
        chk("nan_clean_run", 80'(m_nan), 80'(0));
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
